// File: rtl/ascii_to_mod26_pkg.sv
// Shared character constants and the character-class enum for the ASCII-to-shift converter.
package ascii_to_mod26_pkg;

    localparam logic [7:0] ASCII_LC_A  = 8'd97;
    localparam logic [7:0] ASCII_LC_Z  = 8'd122;
    localparam logic [7:0] ASCII_UC_A  = 8'd65;
    localparam logic [7:0] ASCII_UC_Z  = 8'd90;
    localparam logic [7:0] ASCII_DIG_0 = 8'd48;
    localparam logic [7:0] ASCII_DIG_9 = 8'd57;
    localparam logic [7:0] ALPHA_SIZE  = 8'd26;

    typedef enum logic [1:0] {
        CLS_LOWER = 2'd0,
        CLS_UPPER = 2'd1,
        CLS_DIGIT = 2'd2,
        CLS_OTHER = 2'd3
    } char_class_e;

    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/ascii_to_mod26_classify.sv
// Combinational character classifier: returns the class and the base offset to subtract.
// Digits are treated as a convertible class only when ASCII_MOD26_DIGIT_EN is defined.
module ascii_char_classify
    import ascii_to_mod26_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic [1:0] cls_o,
    output logic [7:0] base_o
);

    char_class_e cls;

    always_comb begin
        cls    = CLS_OTHER;
        base_o = 8'd0;
        if (in_range(ascii_i, ASCII_LC_A, ASCII_LC_Z)) begin
            cls    = CLS_LOWER;
            base_o = ASCII_LC_A;
        end else if (in_range(ascii_i, ASCII_UC_A, ASCII_UC_Z)) begin
            cls    = CLS_UPPER;
            base_o = ASCII_UC_A;
        end
`ifdef ASCII_MOD26_DIGIT_EN
        else if (in_range(ascii_i, ASCII_DIG_0, ASCII_DIG_9)) begin
            cls    = CLS_DIGIT;
            base_o = ASCII_DIG_0;
        end
`endif
    end

    assign cls_o = cls;

endmodule

// File: rtl/ascii_to_mod26.sv
// ASCII key character to Caesar/Vigenere shift (0..25), one registered stage with valid/error.
// Build option: define ASCII_MOD26_DIGIT_EN to map '0'..'9' to shifts 0..9.
module ascii_to_mod26
    import ascii_to_mod26_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             keyboard_clk,
    input  logic             reset,
    input  logic [7:0]       ascii_in,
    input  logic             valid_in,
    output logic [OUT_W-1:0] mod26_out,
    output logic             valid_out,
    output logic             err_out
);

    logic [1:0]       cls_raw;
    char_class_e      cls;
    logic [7:0]       base;
    logic [7:0]       shift;
    logic [OUT_W-1:0] mod26_d, mod26_q;
    logic             err_d, err_q;
    logic             valid_q;

    ascii_char_classify u_classify (
        .ascii_i (ascii_in),
        .cls_o   (cls_raw),
        .base_o  (base)
    );

    // Unconvertible characters fall back to the identity shift.
    function automatic logic [7:0] to_shift(input logic [7:0] c, input logic [7:0] b,
                                            input char_class_e k);
        logic [7:0] diff;
        diff = c - b;
        if (k == CLS_OTHER || diff >= ALPHA_SIZE)
            return 8'd0;
        return diff;
    endfunction

    always_comb begin
        cls     = char_class_e'(cls_raw);
        shift   = to_shift(ascii_in, base, cls);
        mod26_d = OUT_W'(shift);
        err_d   = (cls == CLS_OTHER);
    end

    // Output register stage: result and error hold across idle cycles.
    always_ff @(posedge keyboard_clk or posedge reset) begin
        if (reset) begin
            mod26_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                mod26_q <= mod26_d;
                err_q   <= err_d;
            end
        end
    end

    assign mod26_out = mod26_q;
    assign err_out   = err_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_ascii_to_mod26.sv
// Scoreboard bench for ascii_to_mod26: expected results queued at drive time, popped on valid_out.
module tb_ascii_to_mod26;

    localparam int OUT_W = 8;

    typedef struct {
        int mod;
        int err;
        string tag;
    } exp_t;

    logic             keyboard_clk;
    logic             reset;
    logic [7:0]       ascii_in;
    logic             valid_in;
    logic [OUT_W-1:0] mod26_out;
    logic             valid_out;
    logic             err_out;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    ascii_to_mod26 #(.OUT_W(OUT_W)) dut (
        .keyboard_clk (keyboard_clk),
        .reset        (reset),
        .ascii_in     (ascii_in),
        .valid_in     (valid_in),
        .mod26_out    (mod26_out),
        .valid_out    (valid_out),
        .err_out      (err_out)
    );

    initial keyboard_clk = 1'b0;
    always #5 keyboard_clk = ~keyboard_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // Reference model written straight from the character table.
    function automatic exp_t model(input int c, input string tag);
        exp_t e;
        e.tag = tag;
        e.mod = 0;
        e.err = 1;
        if (c >= 97 && c <= 122) begin
            e.mod = c - 97; e.err = 0;
        end else if (c >= 65 && c <= 90) begin
            e.mod = c - 65; e.err = 0;
        end
`ifdef ASCII_MOD26_DIGIT_EN
        else if (c >= 48 && c <= 57) begin
            e.mod = c - 48; e.err = 0;
        end
`endif
        return e;
    endfunction

    task automatic drive(input int c, input string tag);
        @(negedge keyboard_clk);
        ascii_in = 8'(c);
        valid_in = 1'b1;
        sb_q.push_back(model(c, tag));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge keyboard_clk);
            valid_in = 1'b0;
            ascii_in = 8'hxx;
        end
    endtask

    always @(negedge keyboard_clk) begin
        if (reset === 1'b0 && valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_mod"}, int'(mod26_out), e.mod);
                check({e.tag, "_err"}, int'(err_out), e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ascii_in = 8'd0;
        valid_in = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_mod", int'(mod26_out), 0);
        check("rst_valid", int'(valid_out), 0);
        check("rst_err", int'(err_out), 0);
        repeat (2) @(negedge keyboard_clk);
        reset = 1'b0;

        drive(97, "lc_a");
        drive(122, "lc_z");
        drive(107, "lc_k");
        drive(65, "uc_A");
        drive(90, "uc_Z");
        drive(77, "uc_M");
        drive(64, "b_64");
        drive(91, "b_91");
        drive(96, "b_96");
        drive(123, "b_123");
        drive(255, "b_255");
        drive(0, "b_0");
        drive(53, "dig_5");
        drive(48, "dig_0");
        drive(57, "dig_9");
        drive(47, "b_47");
        drive(58, "b_58");
        idle(2);

        for (int i = 0; i < 40; i++) drive($urandom_range(0, 255), "rnd");
        idle(2);

        // Capture 'q', then confirm the result holds while valid_in stays low.
        drive(113, "hold_q");
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge keyboard_clk);
            check("hold_mod", int'(mod26_out), 16);
            check("hold_valid", int'(valid_out), 0);
            check("hold_err", int'(err_out), 0);
        end
        #2 reset = 1'b1;
        #1;
        check("rst2_mod", int'(mod26_out), 0);
        check("rst2_valid", int'(valid_out), 0);
        check("rst2_err", int'(err_out), 0);
        @(negedge keyboard_clk);
        reset = 1'b0;

        // Reset lands just after a capture: the in-flight result is dropped.
        drive(99, "flight_c");
        @(posedge keyboard_clk);
        #1 reset = 1'b1;
        sb_q.delete();
        #1;
        check("rst3_mod", int'(mod26_out), 0);
        check("rst3_valid", int'(valid_out), 0);
        @(negedge keyboard_clk);
        valid_in = 1'b0;
        reset    = 1'b0;
        drive(98, "post_rst_b");
        drive(37, "post_rst_pct");
        idle(3);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
